// File: rtl/uart_word_xmtr.sv
// rtl/uart_word_xmtr.sv - 8N1 UART transmitter that sends each accepted word LSB byte first
//   clock      : system clock; all logic runs on posedge
//   reset      : synchronous, active-high
//   word_data  : word to send, captured only when it is accepted
//   word_valid : producer has a word
//   word_ready : high only in IDLE
//   uart_cts   : host clear-to-send, checked once before each byte
//   uart_tx    : serial line, idle high (registered)
//   busy       : high in every state except IDLE
module uart_word_xmtr #(
    parameter int CLKS_PER_BIT   = 54,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [8*BYTES_PER_WORD-1:0] word_data,
    input  logic                        word_valid,
    output logic                        word_ready,
    input  logic                        uart_cts,
    output logic                        uart_tx,
    output logic                        busy
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CTS,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [BYTE_W-1:0]   r_byte_idx;
    logic [WORD_W-1:0]   r_shift_word;
    logic                r_tx;

    logic                w_accept;
    logic                w_bit_done;
    logic                w_tx_next;
    logic [WORD_W-1:0]   w_shifted;
    logic [7:0]          w_cur_byte;

    assign w_accept   = word_valid && (r_state == S_IDLE);
    assign w_bit_done = (r_baud_cnt == BAUD_LAST);

    // Byte select by shifting so the index never reaches past the word.
    assign w_shifted  = r_shift_word >> {r_byte_idx, 3'b000};
    assign w_cur_byte = w_shifted[7:0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_WAIT_CTS;
            end
            S_WAIT_CTS: begin
                if (uart_cts) w_next_state = S_START;
            end
            S_START: begin
                if (w_bit_done) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_next_state = (r_byte_idx == BYTE_LAST) ? S_IDLE : S_WAIT_CTS;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic; the line level is registered so uart_tx never glitches.
    always_comb begin
        word_ready = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        w_tx_next  = 1'b1;
        case (r_state)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_cur_byte[r_bit_idx];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

    assign uart_tx = r_tx;

    // Baud, bit and byte counters plus the captured word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift_word <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift_word <= word_data;
                        r_byte_idx   <= '0;
                    end
                end
                S_WAIT_CTS: begin
                    if (uart_cts) r_baud_cnt <= '0;
                end
                S_START, S_DATA, S_STOP: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (r_state == S_START) r_bit_idx <= '0;
                        if (r_state == S_DATA)  r_bit_idx <= r_bit_idx + 3'd1;
                        if ((r_state == S_STOP) && (r_byte_idx != BYTE_LAST)) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_xmtr.sv
// tb/tb_uart_word_xmtr.sv - self-checking bench for uart_word_xmtr
module tb_uart_word_xmtr;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] word_data, word_data_b;
    logic        word_valid, word_valid_b;
    logic        uart_cts, cts_b;
    logic        word_ready, busy, uart_tx;
    logic        word_ready_b, busy_b, uart_tx_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_word_xmtr dut (
        .clock(clock), .reset(reset), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .uart_cts(uart_cts), .uart_tx(uart_tx), .busy(busy)
    );

    uart_word_xmtr #(.CLKS_PER_BIT(4), .BYTES_PER_WORD(4)) dut_b (
        .clock(clock), .reset(reset), .word_data(word_data_b), .word_valid(word_valid_b),
        .word_ready(word_ready_b), .uart_cts(cts_b), .uart_tx(uart_tx_b), .busy(busy_b)
    );

    // Host-side receiver model: mid-bit sampling, records start-edge cycles and bytes.
    logic       rx_sel = 1'b0;
    logic       rx_line;
    logic [7:0] rx_q[$];
    int         fall_q[$];
    int         frame_errs = 0;

    assign rx_line = rx_sel ? uart_tx_b : uart_tx;

    always begin
        @(posedge clock); #2;
        if (rx_line == 1'b0) begin : frame
            int cpb;
            int t0;
            logic [7:0] b;
            cpb = rx_sel ? 4 : 54;
            t0  = cyc;
            repeat (cpb / 2) begin @(posedge clock); #2; end
            if (rx_line == 1'b0) begin
                fall_q.push_back(t0);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) begin @(posedge clock); #2; end
                    b[i] = rx_line;
                end
                repeat (cpb) begin @(posedge clock); #2; end
                if (rx_line !== 1'b1) frame_errs++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rx_word(input int base);
        return {rx_q[base+3], rx_q[base+2], rx_q[base+1], rx_q[base]};
    endfunction

    task automatic send(input bit sel, input logic [31:0] w, input bit hold, output int acc);
        logic rdy;
        acc = -1;
        if (sel) begin word_data_b = w; word_valid_b = 1'b1; end
        else     begin word_data   = w; word_valid   = 1'b1; end
        for (int k = 0; k < 5000 && acc < 0; k++) begin
            rdy = sel ? word_ready_b : word_ready;
            tick;
            if (rdy) acc = cyc;
        end
        if (!hold) begin
            if (sel) word_valid_b = 1'b0;
            else     word_valid   = 1'b0;
        end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input bit sel, output int t);
        t = -1;
        for (int k = 0; k < 6000 && t < 0; k++) begin
            tick;
            if (sel ? word_ready_b : word_ready) t = cyc;
        end
        if (t < 0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_word;
        int          exp_cycles;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int acc, acc2, t, bad, c, nf;
        logic [9:0] lv;

        vecs[0] = '{32'h04030201, 32'h04030201, 2164};
        vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 2164};
        vecs[2] = '{32'h00000000, 32'h00000000, 2164};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2164};
        vecs[4] = '{32'h80000001, 32'h80000001, 2164};

        reset = 1'b1; word_data = '0; word_data_b = '0;
        word_valid = 1'b0; word_valid_b = 1'b0; uart_cts = 1'b1; cts_b = 1'b1;

        // Reset state
        repeat (3) tick;
        check("reset_tx", uart_tx, 1'b1);
        check("reset_ready", word_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin tick; if (uart_tx !== 1'b1) bad++; end
        check("idle_line_high", bad, 0);

        // Table-driven words
        foreach (vecs[i]) begin
            rx_q.delete(); fall_q.delete();
            send(1'b0, vecs[i].word, 1'b0, acc);
            wait_idle(1'b0, t);
            check("word_time", t - acc, vecs[i].exp_cycles);
            check("nbytes", rx_q.size(), 4);
            if (rx_q.size() >= 4) check("word_value", rx_word(0), vecs[i].exp_word);
            check("nfalls", fall_q.size(), 4);
            if (fall_q.size() >= 4) begin
                check("first_fall_latency", fall_q[0] - acc, 2);
                bad = 0;
                for (int j = 0; j < 3; j++) if (fall_q[j+1] - fall_q[j] != 541) bad++;
                check("byte_spacing", bad, 0);
            end
        end

        // Bit order and hold time of 8'hA5
        rx_q.delete(); fall_q.delete();
        lv = 10'b1101001010;
        send(1'b0, 32'h000000A5, 1'b0, acc);
        tick;
        check("pre_start_high", uart_tx, 1'b1);
        for (int l = 0; l < 10; l++) begin
            bad = 0;
            repeat (54) begin tick; if (uart_tx !== lv[l]) bad++; end
            check($sformatf("a5_level%0d", l), bad, 0);
        end
        wait_idle(1'b0, t);
        if (rx_q.size() >= 4) check("a5_word", rx_word(0), 32'h000000A5);
        else check("a5_nbytes", rx_q.size(), 4);

        // Flow control
        rx_q.delete(); fall_q.delete();
        uart_cts = 1'b0;
        send(1'b0, 32'h55AA33CC, 1'b0, acc);
        bad = 0;
        repeat (500) begin tick; if (uart_tx !== 1'b1 || busy !== 1'b1) bad++; end
        check("cts_stall", bad, 0);
        c = cyc;
        uart_cts = 1'b1;
        tick;
        check("cts_release_high", uart_tx, 1'b1);
        tick;
        check("cts_release_start", uart_tx, 1'b0);
        repeat (200) tick;
        uart_cts = 1'b0;
        while (cyc < c + 600) tick;
        bad = 0;
        repeat (600) begin tick; if (uart_tx !== 1'b1 || busy !== 1'b1) bad++; end
        check("cts_mid_stall", bad, 0);
        check("cts_mid_nbytes", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("cts_byte0", rx_q[0], 8'hCC);
        uart_cts = 1'b1;
        wait_idle(1'b0, t);
        if (rx_q.size() >= 4) check("cts_word", rx_word(0), 32'h55AA33CC);
        else check("cts_nbytes", rx_q.size(), 4);

        // Back-to-back words with word_valid held
        rx_q.delete(); fall_q.delete();
        send(1'b0, 32'hDEADBEEF, 1'b1, acc);
        word_data = 32'h00000001;
        send(1'b0, 32'h00000001, 1'b0, acc2);
        check("b2b_accept_gap", acc2 - acc, 2165);
        wait_idle(1'b0, t);
        check("b2b_nbytes", rx_q.size(), 8);
        if (rx_q.size() >= 8) begin
            check("b2b_word0", rx_word(0), 32'd3735928559);
            check("b2b_word1", rx_word(4), 32'd1);
        end
        if (fall_q.size() >= 5) check("b2b_word_gap", fall_q[4] - fall_q[3], 542);
        else check("b2b_nfalls", fall_q.size(), 8);

        // Reset during DATA of byte 2
        rx_q.delete(); fall_q.delete();
        send(1'b0, 32'hCAFEF00D, 1'b0, acc);
        repeat (1238) tick;
        check("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        tick;
        check("abort_tx", uart_tx, 1'b1);
        check("abort_ready", word_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        reset = 1'b0;
        nf = fall_q.size();
        bad = 0;
        repeat (1500) begin tick; if (uart_tx !== 1'b1) bad++; end
        check("abort_line_high", bad, 0);
        check("abort_no_new_bytes", fall_q.size(), nf);

        // CLKS_PER_BIT = 4 instance
        rx_sel = 1'b1;
        rx_q.delete(); fall_q.delete();
        send(1'b1, 32'h12345678, 1'b0, acc);
        wait_idle(1'b1, t);
        check("p4_word_time", t - acc, 164);
        repeat (5) tick;
        if (rx_q.size() >= 4) check("p4_word", rx_word(0), 32'd305419896);
        else check("p4_nbytes", rx_q.size(), 4);
        rx_sel = 1'b0;

        check("frame_errors", frame_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_word_xmtr.md
Name: uart_word_xmtr

Overview:
UART 8N1 transmitter that serializes 32-bit result words from the detection pipeline, such as face coordinates or counts, onto uart_tx. Each word is sent as 4 bytes, least-significant byte first. The host-side receiver reassembles words in that same order. Sits between the result arbiter in top and the uart_tx pin, and honours the host's uart_cts flow control.

Parameters:
- CLKS_PER_BIT, 54, clock cycles per UART bit period (50 MHz system clock).
- BYTES_PER_WORD, 4, bytes per accepted word; word width is 8*BYTES_PER_WORD.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- word_data  in  8*BYTES_PER_WORD  word to send; sampled only on accept.
- word_valid  in  1  producer has a word.
- word_ready  out  1  transmitter can accept a word (high only in IDLE).
- uart_cts  in  1  host clear-to-send, active-high (1 = may send).
- uart_tx  out  1  serial line, idle high.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset:
- Outputs after reset: uart_tx=1, word_ready=1, busy=0.
- State goes to IDLE. All counters clear.
- Reset during a transfer aborts it. uart_tx=1 from the cycle after reset is sampled. The partial word is dropped and not resent.

Accept:
- A word is accepted on a posedge where word_valid && word_ready.
- On accept: latch word_data into shift_word, set byte_idx=0, go to WAIT_CTS.
- word_ready is driven combinationally from state (IDLE). word_valid outside IDLE is ignored.

States:
- IDLE: uart_tx=1. On accept, go to WAIT_CTS.
- WAIT_CTS: uart_tx=1. uart_cts is checked only here, once per byte. If uart_cts=1, go to START and clear baud_cnt. Otherwise stay.
- START: uart_tx=0 for CLKS_PER_BIT cycles. At baud_cnt==CLKS_PER_BIT-1, go to DATA with bit_idx=0.
- DATA: uart_tx=current_byte[bit_idx], bits sent LSB first. Each bit is held CLKS_PER_BIT cycles. After bit_idx==7 completes, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if byte_idx==BYTES_PER_WORD-1, go to IDLE. Otherwise increment byte_idx and go to WAIT_CTS.
- current_byte = shift_word[8*byte_idx +: 8].

Timing:
- With uart_cts=1 throughout, uart_tx first goes low 2 cycles after the accept edge (1 cycle in WAIT_CTS).
- Each byte occupies 10*CLKS_PER_BIT cycles on the line, plus 1 WAIT_CTS cycle.
- Full word with default parameters: 4*(540+1) = 2164 cycles from accept to word_ready re-asserting.

Counters:
- baud_cnt is wide enough for CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- bit_idx is 3 bits; byte_idx is $clog2(BYTES_PER_WORD) bits (minimum 1).
- No arithmetic is performed on data.

Boundaries:
- uart_cts dropping mid-byte does not interrupt that byte. The stall takes effect at the next WAIT_CTS.
- uart_cts held low keeps the block in WAIT_CTS indefinitely with uart_tx=1, busy=1.
- Back-to-back words: word_valid held high is accepted on the first IDLE cycle. The line then shows the stop bit, one idle-high cycle (the IDLE cycle), one WAIT_CTS cycle, then the start bit.
- word_data changing after accept has no effect.

Test Plan:
- Reset: hold reset 3 cycles, word_valid=0 -> uart_tx=1, word_ready=1, busy=0. Line stays high for 1000 cycles.
- Single word: word_data=32'h04030201, uart_cts=1 -> a host-side uart_rcvr sees bytes 01,02,03,04 in order. Start-bit falling edges occur 541 cycles apart. word_ready rises 2164 cycles after accept.
- Bit order and timing: word_data=32'h000000A5 -> first byte on line is 0,1,0,1,0,0,1,0,1,1 (start, bits LSB first, stop). Each level is held exactly 54 cycles.
- Flow control: uart_cts=0 before accept -> uart_tx stays 1 and busy=1 for 500 cycles. After uart_cts=1, the start bit begins 1 cycle later. Dropping uart_cts mid-byte 0 lets byte 0 finish, then the block stalls before byte 1.
- Back-to-back plus mid-operation reset: two words 32'hDEADBEEF and 32'h00000001 with word_valid held -> the host reassembles 3735928559 then 1. Then assert reset during DATA of byte 2 of a third word -> uart_tx=1 on the next cycle and the host receives no further bytes.
- Parameter override CLKS_PER_BIT=4: word 32'h12345678 -> host receiver configured at 4 cycles per bit recovers 305419896. Total word time is 4*(40+1)=164 cycles.
